// File: rtl/sobel_config_pkg.sv
// Shared configuration for the Sobel host-side controller: state encoding,
// default frame geometry and sizing helpers.
package sobel_config_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_e;

    localparam int IMG_W_DEFAULT   = 8;
    localparam int IMG_H_DEFAULT   = 8;
    localparam int TIMEOUT_DEFAULT = 65535;

    // Pixel count and watchdog width of the default frame geometry.
    localparam int NPIX       = IMG_W_DEFAULT * IMG_H_DEFAULT;
    localparam int WDOG_WIDTH = $clog2(TIMEOUT_DEFAULT + 1);

    // Watchdog width needed to hold the value TIMEOUT.
    function automatic int wdog_bits(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sobel_skid_fifo.sv
// Two-entry skid FIFO holding output-memory read data plus its last flag.
module sobel_skid_fifo #(
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);
    import sobel_config_pkg::*;

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    // Accept a push when not full, or when a pop frees a slot this cycle.
    always_comb begin
        do_pop  = pop_i && (count != 2'd0);
        do_push = push_i && ((count != 2'd2) || do_pop);
    end

    // Entry storage.
    // NOTE: storage is not reset; count gates visibility, so stale entries are never observed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/sobel_host_ctrl.sv
// Host-side sequencer for sobel_top: loads a frame, starts the core, waits
// for finish under a watchdog, then streams the output memory back out.
module sobel_host_ctrl
    import sobel_config_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEFAULT,
    parameter int IMG_H      = IMG_H_DEFAULT,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  go_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  in_ready_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic                  start_o,
    input  logic                  finish_i,
    output logic                  wr_en_imem_o,
    output logic [ADDR_WIDTH-1:0] addr_imem_o,
    output logic [DATA_WIDTH-1:0] data_imem_o,
    output logic                  rd_en_omem_o,
    output logic [ADDR_WIDTH-1:0] addr_omem_o,
    input  logic [DATA_WIDTH-1:0] data_omem_i
);
    localparam int FRAME_NPIX = IMG_W * IMG_H;
    localparam int WDOG_BITS  = wdog_bits(TIMEOUT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_NPIX - 1);
    localparam logic [WDOG_BITS-1:0]  WDOG_LAST = WDOG_BITS'(TIMEOUT - 1);

    ctrl_state_e           state;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic                  rd_all;
    logic [WDOG_BITS-1:0]  wdog;
    logic                  inflight;
    logic                  inflight_last;

    logic                  in_fire;
    logic                  issue;
    logic                  pop;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [1:0]            fifo_count;
    logic                  head_last;

    // Read data returns one cycle after its address; the skid FIFO absorbs it.
    sobel_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk_i      (clk_i),
        .clear_i    (rst_i || abort_i),
        .push_i     (inflight),
        .push_data_i({inflight_last, data_omem_i}),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .count_o    (fifo_count)
    );

    // Handshakes, memory port drive and read-issue decision.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        in_ready_o   = 1'b0;
        in_fire      = 1'b0;
        wr_en_imem_o = 1'b0;
        addr_imem_o  = '0;
        data_imem_o  = '0;
        out_valid_o  = 1'b0;
        out_data_o   = '0;
        out_last_o   = 1'b0;
        pop          = 1'b0;
        done_o       = 1'b0;
        occupancy    = '0;
        issue        = 1'b0;
        head_last    = fifo_head[DATA_WIDTH];

        in_ready_o = (state == LOAD) && !abort_i;
        in_fire    = in_ready_o && in_valid_i;
        if (in_fire) begin
            wr_en_imem_o = 1'b1;
            addr_imem_o  = wcnt;
            data_imem_o  = in_data_i;
        end

        out_valid_o = (fifo_count != 2'd0);
        if (out_valid_o) begin
            out_data_o = fifo_head[DATA_WIDTH-1:0];
            out_last_o = head_last;
        end
        pop    = out_valid_o && out_ready_i;
        done_o = (state == DRAIN) && pop && head_last && !abort_i;

        // Slots in use after this cycle's pop, counting the read still in flight.
        occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
        issue     = (state == DRAIN) && !abort_i && !rd_all && (occupancy < 3'd2);
    end

    assign busy_o       = (state != IDLE);
    assign rd_en_omem_o = (state == DRAIN);
    assign addr_omem_o  = issue ? raddr : addr_hold;

    // Frame sequencer: state, counters, watchdog and registered pulses.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            wcnt          <= '0;
            raddr         <= '0;
            addr_hold     <= '0;
            rd_all        <= 1'b0;
            wdog          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            start_o       <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            start_o       <= 1'b0;
            err_o         <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (raddr == LAST_ADDR);
            if (issue) begin
                addr_hold <= raddr;
                if (raddr == LAST_ADDR) begin
                    rd_all <= 1'b1;
                end else begin
                    raddr <= raddr + ADDR_WIDTH'(1);
                end
            end

            if (abort_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (go_i) begin
                            state <= LOAD;
                            wcnt  <= '0;
                        end
                    end
                    LOAD: begin
                        if (in_fire) begin
                            if (wcnt == LAST_ADDR) begin
                                state   <= RUN;
                                start_o <= 1'b1;
                                wdog    <= '0;
                            end else begin
                                wcnt <= wcnt + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    RUN: begin
                        // start_o marks the first RUN cycle, where finish_i may be stale.
                        if (!start_o && finish_i) begin
                            state  <= DRAIN;
                            raddr  <= '0;
                            rd_all <= 1'b0;
                        end else if (wdog == WDOG_LAST) begin
                            state <= IDLE;
                            err_o <= 1'b1;
                        end else begin
                            wdog <= wdog + WDOG_BITS'(1);
                        end
                    end
                    DRAIN: begin
                        if (done_o) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sobel_host_ctrl.sv
// Directed bench for sobel_host_ctrl on a 4x4 frame with a 20-cycle watchdog.
module tb_sobel_host_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 20;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          go_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic          in_valid_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_last_o;
    logic          out_ready_i;
    logic          start_o;
    logic          finish_i;
    logic          wr_en_imem_o;
    logic [AW-1:0] addr_imem_o;
    logic [DW-1:0] data_imem_o;
    logic          rd_en_omem_o;
    logic [AW-1:0] addr_omem_o;
    logic [DW-1:0] data_omem_i = '0;

    logic [DW-1:0] omem [N];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    sobel_host_ctrl #(
        .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .go_i(go_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .out_ready_i(out_ready_i), .start_o(start_o), .finish_i(finish_i),
        .wr_en_imem_o(wr_en_imem_o), .addr_imem_o(addr_imem_o), .data_imem_o(data_imem_o),
        .rd_en_omem_o(rd_en_omem_o), .addr_omem_o(addr_omem_o), .data_omem_i(data_omem_i)
    );

    // Output memory model: one-cycle read latency.
    always @(posedge clk_i) begin
        if (rd_en_omem_o) data_omem_i <= omem[addr_omem_o[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({busy_o, done_o, err_o, in_ready_o, out_valid_o, out_last_o,
                                  start_o, wr_en_imem_o, rd_en_omem_o}), 0);
        check({tag, "_out_data"}, 32'(out_data_o), 0);
        check({tag, "_addr_imem"}, 32'(addr_imem_o), 0);
        check({tag, "_data_imem"}, 32'(data_imem_o), 0);
        check({tag, "_addr_omem"}, 32'(addr_omem_o), 0);
    endtask

    task automatic preload(input int mult, input int add);
        for (int a = 0; a < N; a++) omem[a] = 8'(a * mult + add);
    endtask

    // Pulse go_i for one cycle from IDLE.
    task automatic start_frame();
        @(negedge clk_i);
        go_i = 1'b1;
        #1 check("idle_before_go", 32'(busy_o), 0);
    endtask

    // Stream pixels back-to-back, checking every input-memory write.
    task automatic stream(input int count, input logic [7:0] base);
        for (int i = 0; i < count; i++) begin
            @(negedge clk_i);
            go_i       = 1'b0;
            in_valid_i = 1'b1;
            in_data_i  = base + 8'(i);
            #1;
            check("wr_en_imem", 32'(wr_en_imem_o), 1);
            check("addr_imem", 32'(addr_imem_o), 32'(i));
            check("data_imem", 32'(data_imem_o), 32'(base + 8'(i)));
        end
    endtask

    // First RUN cycle after the last pixel.
    task automatic expect_start();
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        check("start_pulse", 32'(start_o), 1);
        check("in_ready_run", 32'(in_ready_o), 0);
        check("wr_en_run", 32'(wr_en_imem_o), 0);
    endtask

    // Core model: finish_i asserted 'delay' cycles after start.
    task automatic run_core(input int delay);
        int extra = 0;
        for (int k = 1; k < delay; k++) begin
            @(negedge clk_i);
            #1;
            if (start_o || !busy_o || rd_en_omem_o) extra++;
        end
        @(negedge clk_i);
        finish_i = 1'b1;
        @(negedge clk_i);
        finish_i = 1'b0;
        #1;
        check("start_once_run_held", 32'(extra), 0);
        check("drain_entry", 32'(rd_en_omem_o), 1);
    endtask

    // Drain all pixels; mode 0 keeps out_ready high, mode 1 toggles 1,0,0.
    task automatic drain(input int mode, input int mult, input int add);
        int idx = 0;
        int cyc = 0;
        int bad = 0;
        int first = -1;
        int last = -1;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [7:0] pd = '0;
        while (idx < N && cyc < 300) begin
            @(negedge clk_i);
            out_ready_i = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            #1;
            if (!rd_en_omem_o) bad++;
            if (pv && !pr) check("stall_stable", 32'({out_valid_o, out_data_o}), 32'({1'b1, pd}));
            if (out_valid_o && first < 0) first = cyc;
            if (out_valid_o && out_ready_i) begin
                check("out_data", 32'(out_data_o), 32'(8'(idx * mult + add)));
                check("out_last", 32'(out_last_o), 32'(idx == N - 1));
                check("done_pulse", 32'(done_o), 32'(idx == N - 1));
                idx++;
                last = cyc;
            end else if (done_o) begin
                bad++;
            end
            pv = out_valid_o;
            pr = out_ready_i;
            pd = out_data_o;
            cyc++;
        end
        check("drain_count", 32'(idx), N);
        check("rd_en_drain", 32'(bad), 0);
        if (mode == 0) check("throughput", 32'(last - first + 1), N);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        #1;
        check("busy_after_done", 32'(busy_o), 0);
        check("done_after", 32'(done_o), 0);
    endtask

    initial begin
        int k;
        int bad;
        rst_i = 1'b1; go_i = 1'b0; abort_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0;
        out_ready_i = 1'b0; finish_i = 1'b0;
        preload(3, 0);
        repeat (2) @(negedge clk_i);
        #1 check_all_zero("reset");
        rst_i = 1'b0;

        // Frame A: load 0..15, finish after 10 cycles, drain at full rate.
        start_frame();
        stream(N, 8'd0);
        expect_start();
        run_core(10);
        drain(0, 3, 0);

        // Frame B: finish_i stale-high at start; drain with stalls.
        preload(5, 1);
        finish_i = 1'b1;
        start_frame();
        stream(N, 8'h20);
        expect_start();
        @(negedge clk_i);
        #1;
        check("finish_ignored_start", 32'(rd_en_omem_o), 0);
        check("start_cleared", 32'(start_o), 0);
        @(negedge clk_i);
        finish_i = 1'b0;
        #1 check("finish_taken", 32'(rd_en_omem_o), 1);
        drain(1, 5, 1);

        // Frame C: no finish -> watchdog.
        start_frame();
        stream(N, 8'h40);
        expect_start();
        k = 0;
        bad = 0;
        while (k < 100) begin
            @(negedge clk_i);
            #1;
            k++;
            if (done_o || rd_en_omem_o) bad++;
            if (err_o) break;
        end
        check("err_latency", 32'(k), TO);
        check("err_idle", 32'(busy_o), 0);
        check("no_done_timeout", 32'(bad), 0);
        @(negedge clk_i);
        #1 check("err_once", 32'(err_o), 0);

        // Abort mid-load, then a fresh frame restarts at address 0.
        start_frame();
        stream(7, 8'h80);
        @(negedge clk_i);
        abort_i = 1'b1;
        in_data_i = 8'hEE;
        #1 check("wr_blocked_abort", 32'(wr_en_imem_o), 0);
        @(negedge clk_i);
        abort_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("idle_after_abort", 32'(busy_o), 0);
        check("no_pulse_abort", 32'({done_o, err_o}), 0);
        start_frame();
        stream(N, 8'h90);
        expect_start();
        run_core(3);

        // Reset in the middle of DRAIN.
        repeat (5) begin
            @(negedge clk_i);
            out_ready_i = 1'b1;
        end
        #1 check("mid_drain_busy", 32'(busy_o), 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1 check_all_zero("rst_mid_drain");
        rst_i = 1'b0;
        out_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sobel_host_ctrl.md
Name: sobel_host_ctrl

Overview:
- Host-side sequencer in front of sobel_top. Runs one frame per command.
- Streams an input frame into the input memory through a valid/ready port, pulses start, and waits for finish under a watchdog.
- Then reads the whole output memory back out as a valid/ready pixel stream with a last marker.
- Owns every host-side pin of sobel_top, so the core is never driven by two masters.

Parameters:
- IMG_W, 8, image width in pixels
- IMG_H, 8, image height in pixels
- ADDR_WIDTH, 16, memory address width; must satisfy 2^ADDR_WIDTH >= IMG_W*IMG_H
- DATA_WIDTH, 8, pixel width
- TIMEOUT, 65535, maximum RUN cycles before error

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- go_i  in  1  start one frame; honoured in IDLE only
- abort_i  in  1  abandon the frame, return to IDLE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when the last output pixel is accepted
- err_o  out  1  one-cycle pulse on watchdog expiry
- in_valid_i  in  1  input pixel valid
- in_data_i  in  DATA_WIDTH  input pixel, raster order
- in_ready_o  out  1  controller accepts an input pixel
- out_valid_o  out  1  output pixel valid
- out_data_o  out  DATA_WIDTH  output pixel, raster order
- out_last_o  out  1  marks pixel NPIX-1
- out_ready_i  in  1  sink accepts the output pixel
- start_o  out  1  to sobel_top start_i
- finish_i  in  1  from sobel_top finish_o
- wr_en_imem_o  out  1  to sobel_top wr_en_imem_i
- addr_imem_o  out  ADDR_WIDTH  to addr_imem_i
- data_imem_o  out  DATA_WIDTH  to data_imem_i
- rd_en_omem_o  out  1  to rd_en_omem_i
- addr_omem_o  out  ADDR_WIDTH  to addr_omem_i
- data_omem_i  in  DATA_WIDTH  from data_omem_o

Behaviour:
- NPIX = IMG_W*IMG_H.
- Reset: state IDLE; counters 0; skid FIFO empty. All outputs 0: busy, done, err, in_ready, out_valid, out_data, out_last, start, wr_en_imem, addr/data_imem, rd_en_omem, addr_omem.
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - go_i=1 -> LOAD; wcnt cleared.
- LOAD:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o, combinationally drive wr_en_imem_o=1, addr_imem_o=wcnt, data_imem_o=in_data_i; wcnt increments.
  - Accepting pixel NPIX-1 -> RUN. in_ready_o is 0 from the next cycle.
  - wr_en_imem_o is 0 whenever there is no handshake.
- RUN:
  - start_o=1 for exactly the first RUN cycle.
  - finish_i is ignored in that cycle, because it may be stale from the previous frame. It is sampled from the second RUN cycle on.
  - finish_i=1 -> DRAIN; raddr cleared.
  - Watchdog counts RUN cycles. Reaching TIMEOUT: err_o pulses and the state returns to IDLE.
- DRAIN:
  - rd_en_omem_o=1 for every DRAIN cycle, which blocks core writes to the output memory.
  - Output memory read latency is 1 cycle: data for the address driven in cycle t appears on data_omem_i in t+1.
  - A 2-entry skid FIFO holds read data.
  - A read is issued (addr_omem_o=raddr, raddr++) only when raddr<NPIX and FIFO occupancy plus in-flight reads is < 2. Throughput is 1 pixel/cycle with out_ready_i held high.
  - out_valid_o = FIFO not empty; out_data_o = FIFO head.
  - out_last_o=1 when the head is pixel NPIX-1.
  - Pop on out_valid_o & out_ready_i.
  - Popping the last pixel: done_o pulses the same cycle and the state returns to IDLE.
  - out_valid_o and out_data_o stay stable while out_ready_i=0.
- Priority, highest first: rst_i, abort_i, state logic.
  - abort_i in any state -> IDLE next cycle; FIFO flushed; no done/err pulse.
  - Memory contents already written are left as-is.
- Ignored inputs:
  - go_i outside IDLE.
  - finish_i outside RUN.
  - in_valid_i outside LOAD.
- addr_omem_o holds its last value when no read is issued. rd_en_omem_o alone gates the output-memory port.
- Counters are ADDR_WIDTH bits and never wrap; terminal compare is against NPIX-1.
- The watchdog counter is clog2(TIMEOUT+1) bits.

Decomposition:
- sobel_config_pkg gains:
  - ctrl_state_e enum (IDLE, LOAD, RUN, DRAIN)
  - NPIX localparam
  - WDOG_WIDTH localparam
- One sub-module: sobel_skid_fifo, a 2-deep, DATA_WIDTH+1 wide FIFO carrying data plus the last flag, with push/pop/count and a synchronous active-high clear.

Test Plan:
1. IMG_W=IMG_H=4. go_i, then 16 pixels with values 0..15 streamed back-to-back -> wr_en_imem_o high for 16 consecutive cycles, addr 0..15. start_o pulses once, in the cycle after pixel 15.
2. Core model asserts finish_i 10 cycles after start; output memory preloaded with addr*3 -> 16 outputs 0,3,...,45. out_last_o on value 45 only. done_o pulses on that handshake. busy_o=0 the next cycle.
3. Drain with out_ready_i toggling 1,0,0,1,... -> no pixel lost or duplicated; out_data_o stable while stalled; rd_en_omem_o high throughout DRAIN.
4. finish_i held high from the previous frame when the next start_o fires -> not taken in the start cycle; taken the following cycle.
5. TIMEOUT=20 with finish_i never asserted -> err_o pulses once 20 cycles after start; state IDLE; no done_o.
6. abort_i after 7 of 16 input pixels; then a fresh go_i -> addr_imem_o restarts at 0. Also: rst_i mid-DRAIN -> all outputs 0 the next cycle.
